// File: rtl/ora_and_sig_if.sv
// Handshake bundle between the BIST controller/TPG side and the output response analyser.
interface ora_and_sig_if #(
  parameter int SIG_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             enable;
  logic             resp;
  logic             busy;
  logic             done;
  logic             pass;
  logic             fail;
  logic [SIG_W-1:0] signature;
  logic [CNT_W-1:0] pat_cnt;

  modport master (
    output start, enable, resp,
    input  busy, done, pass, fail, signature, pat_cnt
  );

  modport slave (
    input  start, enable, resp,
    output busy, done, pass, fail, signature, pat_cnt
  );
endinterface

// File: rtl/ora_and_sig.sv
// Output response analyser: compacts CUT responses into a serial LFSR signature
// over N_PAT samples, then compares against a golden signature.
module ora_and_sig #(
  parameter int             SIG_W  = 8,
  parameter logic [SIG_W-1:0] POLY = 'h1D,
  parameter int             N_PAT  = 4,
  parameter logic [SIG_W-1:0] GOLDEN = 'h02,
  parameter int             CNT_W  = 8
) (
  input logic          clk,
  input logic          init,
  ora_and_sig_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_t;

  state_t           state, state_nxt;
  logic [SIG_W-1:0] sig, sig_nxt;
  logic [CNT_W-1:0] cnt;
  logic             pass_r, fail_r;
  logic             sample, clear, last;

  assign sample = (state == RUN) && bus.enable;
  assign clear  = ((state == IDLE) || (state == DONE)) && bus.start;
  assign last   = (cnt == CNT_W'(N_PAT - 1));

  always_comb begin
    sig_nxt = {sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? POLY : '0)
            ^ {{(SIG_W-1){1'b0}}, bus.resp};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (sample && last) state_nxt = CHECK;
      CHECK:   state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (init) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (init) begin
      sig    <= '0;
      cnt    <= '0;
      pass_r <= 1'b0;
      fail_r <= 1'b0;
    end else if (clear) begin
      sig    <= '0;
      cnt    <= '0;
      pass_r <= 1'b0;
      fail_r <= 1'b0;
    end else begin
      if (sample) begin
        sig <= sig_nxt;
        // Saturate so a run can never wrap the counter.
        if (cnt != CNT_W'(N_PAT)) cnt <= cnt + CNT_W'(1);
      end
      if (state == CHECK) begin
        pass_r <= (sig == GOLDEN);
        fail_r <= (sig != GOLDEN);
      end
    end
  end

  assign bus.busy      = (state == RUN) || (state == CHECK);
  assign bus.done      = (state == DONE);
  assign bus.pass      = pass_r;
  assign bus.fail      = fail_r;
  assign bus.signature = sig;
  assign bus.pat_cnt   = cnt;

endmodule

// File: tb/tb_ora_and_sig.sv
// Randomized scoreboard bench for ora_and_sig: signatures modelled as polynomial
// remainders over GF(2), compared by a monitor on each rising done.
module tb_ora_and_sig;
  logic clk = 1'b0;
  logic init;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ora_and_sig_if #(.SIG_W(8), .CNT_W(8)) bus ();

  ora_and_sig dut (.clk(clk), .init(init), .bus(bus));

  typedef struct {
    logic [7:0] sig;
    logic       pass;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  // Signature = (previous * x + resp) mod (x^8 + x^4 + x^3 + x^2 + 1).
  function automatic logic [7:0] sig_step(input logic [7:0] s, input logic r);
    int v;
    v = (int'(s) << 1) | int'(r);
    if (v >= 256) v = v ^ 'h11D;
    return v[7:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per rising done; checks flag consistency every cycle.
  logic done_d = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!init) begin
      chk("pass_fail_excl", {31'd0, bus.pass & bus.fail}, 32'd0);
      if (!bus.done) chk("flags_zero_when_not_done", {30'd0, bus.pass, bus.fail}, 32'd0);
      if (bus.done && !done_d) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got done=1 expected no result pending");
        end else begin
          e = sb.pop_front();
          chk("signature", {24'd0, bus.signature}, {24'd0, e.sig});
          chk("pass", {31'd0, bus.pass}, {31'd0, e.pass});
          chk("fail", {31'd0, bus.fail}, {31'd0, ~e.pass});
          chk("pat_cnt", {24'd0, bus.pat_cnt}, 32'd4);
          chk("done_latency", cyc, e.cyc);
        end
      end
    end
    done_d = bus.done;
  end

  task automatic do_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  // Feeds n samples (r[0] first); gap<0 gives random gaps, else fixed gap cycles.
  task automatic feed(input logic [3:0] r, input int n, input int gap,
                      inout logic [7:0] s, output int last_cyc);
    last_cyc = 0;
    for (int i = 0; i < n; i++) begin
      repeat (gap < 0 ? $urandom_range(0, 3) : gap) step();
      bus.enable = 1'b1;
      bus.resp   = r[i];
      step();
      last_cyc = cyc;
      s = sig_step(s, r[i]);
      bus.enable = 1'b0;
      bus.resp   = $urandom_range(0, 1);
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (!bus.done && k < 10) begin
      step();
      k++;
    end
    if (!bus.done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 10 cycles");
    end
    step();
  endtask

  task automatic full_run(input logic [3:0] r, input int gap);
    logic [7:0] s;
    int         lc;
    exp_t       e;
    s = 8'h00;
    do_start();
    feed(r, 4, gap, s, lc);
    e.sig  = s;
    e.pass = (s == 8'h02);
    e.cyc  = lc + 1;
    sb.push_back(e);
    wait_done();
  endtask

  initial begin
    logic [7:0] s;
    int         lc;
    logic [7:0] held;

    init = 1'b1;
    bus.start = 1'b0;
    bus.enable = 1'b0;
    bus.resp = 1'b0;
    repeat (2) step();
    init = 1'b0;
    step();
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_sig", {24'd0, bus.signature}, 32'd0);
    chk("rst_cnt", {24'd0, bus.pat_cnt}, 32'd0);

    // Enable pulses in IDLE must be ignored.
    for (int i = 0; i < 3; i++) begin
      bus.enable = 1'b1;
      bus.resp = 1'b1;
      step();
    end
    bus.enable = 1'b0;
    chk("idle_en_sig", {24'd0, bus.signature}, 32'd0);
    chk("idle_en_cnt", {24'd0, bus.pat_cnt}, 32'd0);
    chk("idle_en_busy", {31'd0, bus.busy}, 32'd0);

    full_run(4'b0100, 0);   // good AND: 0,0,1,0
    full_run(4'b0000, 0);   // stuck-at-0
    full_run(4'b0100, 3);   // good AND with gaps
    full_run(4'b1111, 0);   // stuck-at-1, ends in DONE with fail

    // DONE holds under enable pulses.
    held = bus.signature;
    chk("sa1_sig", {24'd0, held}, 32'h0F);
    repeat (3) begin
      bus.enable = 1'b1;
      step();
    end
    bus.enable = 1'b0;
    chk("done_hold_sig", {24'd0, bus.signature}, {24'd0, held});
    chk("done_hold_cnt", {24'd0, bus.pat_cnt}, 32'd4);
    chk("done_hold_done", {31'd0, bus.done}, 32'd1);

    // Restart from DONE: flags clear right after the start edge.
    do_start();
    chk("restart_done", {31'd0, bus.done}, 32'd0);
    chk("restart_fail", {31'd0, bus.fail}, 32'd0);
    chk("restart_busy", {31'd0, bus.busy}, 32'd1);
    chk("restart_cnt", {24'd0, bus.pat_cnt}, 32'd0);
    s = 8'h00;
    feed(4'b0100, 4, -1, s, lc);
    sb.push_back('{sig: s, pass: 1'b1, cyc: lc + 1});
    wait_done();

    // Partial run, start ignored in RUN, then init discards it.
    do_start();
    s = 8'h00;
    feed(4'b0011, 2, 0, s, lc);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("run_start_cnt", {24'd0, bus.pat_cnt}, 32'd2);
    chk("run_start_sig", {24'd0, bus.signature}, {24'd0, s});
    chk("run_start_busy", {31'd0, bus.busy}, 32'd1);
    init = 1'b1;
    bus.start = 1'b1;
    bus.enable = 1'b1;
    step();
    init = 1'b0;
    bus.start = 1'b0;
    bus.enable = 1'b0;
    chk("init_busy", {31'd0, bus.busy}, 32'd0);
    chk("init_done", {31'd0, bus.done}, 32'd0);
    chk("init_sig", {24'd0, bus.signature}, 32'd0);
    chk("init_cnt", {24'd0, bus.pat_cnt}, 32'd0);
    full_run(4'b0100, 0);

    // Random response patterns with random gaps.
    for (int t = 0; t < 12; t++) full_run(4'($urandom_range(0, 15)), -1);

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
